// File: rtl/mdu_pkg.sv
// Shared op encodings and FSM states for the multiply/divide unit.
// Helpers decode the op field into divide/signed flags.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } mdu_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_abs.sv
// Conditional two's-complement negate: y = neg ? -x : x.
// Used for operand magnitudes and result sign correction.
module mdu_abs #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one bit per RUN cycle.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opb_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             div_q, qneg_q, rneg_q, dz_q;

  logic             open, accept, sgn, sa, sb, dz_now;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_shl;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff, nxt_hi, nxt_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign open   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept = start & open;
  assign sgn    = op_is_signed(op);
  assign sa     = sgn & a[WIDTH-1];
  assign sb     = sgn & b[WIDTH-1];
  assign dz_now = op_is_div(op) & (b == '0);

  mdu_abs #(.W(WIDTH)) u_abs_a (.neg(sa), .x(a), .y(mag_a));
  mdu_abs #(.W(WIDTH)) u_abs_b (.neg(sb), .x(b), .y(mag_b));

  mdu_abs #(.W(2*WIDTH)) u_fix_p (
    .neg(qneg_q),
    .x  ({acc_hi_q, acc_lo_q}),
    .y  (prod_fix)
  );
  mdu_abs #(.W(WIDTH)) u_fix_q (
    .neg(qneg_q), .x(acc_lo_q), .y(quo_fix)
  );
  mdu_abs #(.W(WIDTH)) u_fix_r (
    .neg(rneg_q), .x(acc_hi_q), .y(rem_fix)
  );

  // acc_hi holds partial product / remainder,
  // acc_lo holds multiplier / dividend-then-quotient.
  always_comb begin
    mul_sum  = {1'b0, acc_hi_q}
             + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    div_shl  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge   = div_shl >= {1'b0, opb_q};
    div_diff = div_shl[WIDTH-1:0] - opb_q;
    if (div_q) begin
      nxt_hi = div_ge ? div_diff : div_shl[WIDTH-1:0];
      nxt_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = dz_now ? S_DONE : S_RUN;
        else       state_d = S_IDLE;
      end
      S_RUN:   if (cnt_q == LAST) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // The final RUN cycle (cnt == WIDTH) only hands off to FIX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      div_q    <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else if (accept) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= mag_a;
      opb_q    <= mag_b;
      div_q    <= op_is_div(op);
      qneg_q   <= sa ^ sb;
      rneg_q   <= sa;
      dz_q     <= dz_now;
    end else if (state_q == S_RUN && cnt_q != LAST) begin
      cnt_q    <= cnt_q + CW'(1);
      acc_hi_q <= nxt_hi;
      acc_lo_q <= nxt_lo;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == S_FIX) begin
      if (div_q) begin
        hi_q <= rem_fix;
        lo_q <= quo_fix;
      end else begin
        {hi_q, lo_q} <= prod_fix;
      end
    end else if (open) begin
      if (hi_wr) hi_q <= wdata;
      if (lo_wr) lo_q <= wdata;
    end
  end

  assign busy     = (state_q == S_RUN) || (state_q == S_FIX);
  assign done     = (state_q == S_DONE);
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed corner cases plus
// random ops checked against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         hi_wr = 1'b0;
  logic         lo_wr = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .hi_wr   (hi_wr),
    .lo_wr   (lo_wr),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_hi"}, hi, e.hi);
        chk({e.tag, "_lo"}, lo, e.lo);
        chk({e.tag, "_dz"}, {31'd0, div_zero}, {31'd0, e.dz});
        chk({e.tag, "_cycle"}, cyc, e.cyc);
      end
    end
  end

  // Called at posedge+1 with the DUT in IDLE or DONE.
  task automatic do_op(input string tag, input logic [1:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic hw, input logic lw,
                       input logic [31:0] wd);
    exp_t e;
    longint sx, sy;
    longint unsigned ux, uy;
    logic [63:0] p;
    op = o; a = x; b = y;
    hi_wr = hw; lo_wr = lw; wdata = wd;
    start = 1'b1;
    if (hw) mdl_hi = wd;
    if (lw) mdl_lo = wd;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    e.dz = 1'b0;
    e.tag = tag;
    case (o)
      2'b00: begin
        p = sx * sy;
        mdl_hi = p[63:32]; mdl_lo = p[31:0];
      end
      2'b01: begin
        p = ux * uy;
        mdl_hi = p[63:32]; mdl_lo = p[31:0];
      end
      2'b10: begin
        if (y == 0) e.dz = 1'b1;
        else begin
          mdl_lo = 32'(sx / sy);
          mdl_hi = 32'(sx % sy);
        end
      end
      default: begin
        if (y == 0) e.dz = 1'b1;
        else begin
          mdl_lo = 32'(ux / uy);
          mdl_hi = 32'(ux % uy);
        end
      end
    endcase
    e.hi = mdl_hi;
    e.lo = mdl_lo;
    e.cyc = cyc + (e.dz ? 1 : 35);
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int k = 0; k < 80; k++) begin
      if (done) return;
      @(posedge clk); #1;
    end
    chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb, rw;
    int          seen;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dz", {31'd0, div_zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;

    // First start right after reset release; latency checked by monitor.
    do_op("mult_neg", 2'b00, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, 32'd0);
    chk("mult_busy", {31'd0, busy}, 32'd1);
    wait_done("mult_neg");
    chk("mult_neg_hi_const", hi, 32'hFFFFFFFF);
    chk("mult_neg_lo_const", lo, 32'hFFFFFFFA);

    do_op("multu", 2'b01, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, 32'd0);
    wait_done("multu");
    chk("multu_hi_const", hi, 32'h00000002);
    chk("multu_lo_const", lo, 32'hFFFFFFFA);

    do_op("div_neg7", 2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 32'd0);
    wait_done("div_neg7");
    chk("div_neg7_lo_const", lo, 32'hFFFFFFFD);
    chk("div_neg7_hi_const", hi, 32'hFFFFFFFF);

    do_op("div_wrap", 2'b10, 32'h80000000, 32'hFFFFFFFF,
          1'b0, 1'b0, 32'd0);
    wait_done("div_wrap");
    chk("div_wrap_lo_const", lo, 32'h80000000);
    chk("div_wrap_hi_const", hi, 32'h00000000);
    @(posedge clk); #1;

    lo_wr = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    lo_wr = 1'b0;
    mdl_lo = 32'h1234;
    chk("mtlo", lo, 32'h1234);
    do_op("divu_zero", 2'b11, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("dz_busy", {31'd0, busy}, 32'd0);
    chk("dz_done", {31'd0, done}, 32'd1);
    chk("dz_lo_const", lo, 32'h1234);
    @(posedge clk); #1;

    // Restart and MTHI while busy must both be ignored.
    do_op("mult_ign", 2'b00, 32'd1000, 32'hFFFFFFF0,
          1'b0, 1'b0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; op = 2'b01; a = 32'hDEADBEEF; b = 32'h77;
    chk("ign_busy_start", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    hi_wr = 1'b1; wdata = 32'hCAFEF00D;
    chk("ign_busy_wr", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    hi_wr = 1'b0;
    wait_done("mult_ign");
    @(posedge clk); #1;

    // Async reset mid-divide aborts the operation.
    do_op("div_abort", 2'b10, 32'd12345, 32'd7, 1'b0, 1'b0, 32'd0);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_dz", {31'd0, div_zero}, 32'd0);
    sb.delete();
    mdl_hi = '0;
    mdl_lo = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (45) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("abort_no_done", seen, 32'd0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: ra = 32'($urandom_range(0, 50));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      rw = $urandom;
      do_op($sformatf("rnd%0d", i), ro, ra, rb,
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0), rw);
      wait_done($sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
